// File: rtl/count_chk_pkg.sv
// Shared definitions for the count sequence checker: FSM states and
// default sizing constants.
package count_chk_pkg;

  // Checker FSM states: waiting for a first sample, acquiring lock, locked.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_LOCK_N = 2;
  localparam int DEF_CNT_W  = 8;

  // good_cnt only has to reach LOCK_N, which is at most 15.
  localparam int GOOD_W = 4;

endpackage

// File: rtl/count_checker_sat_counter.sv
// Event counter with optional saturation at all-ones. With sat_en low it
// simply wraps modulo 2^W.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         sat_en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_max;

  assign at_max = (count_q == {W{1'b1}});

  // Next count: bump on inc unless saturation is enabled and we are pinned.
  always_comb begin
    count_d = count_q;
    if (inc && !(sat_en && at_max)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared asynchronously by the checker reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_checker.sv
// Watches an up-counter's output q and checks that it increments by one
// each clock. Locks after LOCK_N consecutive good increments, then flags
// every sequence break with a one-cycle err pulse and counts errors and wraps.
module count_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOCK_N = DEF_LOCK_N,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q,
  input  logic             dut_reset,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  chk_state_e        state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [WIDTH-1:0]  prev_q_q, prev_q_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              err_inc;
  logic              wrap_inc;
  logic              good;
  logic [GOOD_W-1:0] good_cnt_inc;

  // q == prev_q + 1 with natural wrap; a repeated value is a failure.
  assign good         = (q == prev_q_q + WIDTH'(1));
  assign good_cnt_inc = good_cnt_q + GOOD_W'(1);

  // Next-state and output decode for one sample of q / dut_reset.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    prev_q_d   = prev_q_q;
    err_d      = 1'b0;
    err_inc    = 1'b0;
    wrap_inc   = 1'b0;
    if (dut_reset) begin
      state_d    = IDLE;
      good_cnt_d = '0;
    end else begin
      prev_q_d = q;
      case (state_q)
        IDLE: begin
          state_d    = SYNC;
          good_cnt_d = '0;
        end
        SYNC: begin
          if (good) begin
            good_cnt_d = good_cnt_inc;
            if (good_cnt_inc == GOOD_W'(LOCK_N)) begin
              state_d = LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (good) begin
            wrap_inc = (prev_q_q == {WIDTH{1'b1}}) && (q == '0);
          end else begin
            err_d      = 1'b1;
            err_inc    = 1'b1;
            state_d    = SYNC;
            good_cnt_d = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          good_cnt_d = '0;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // FSM state, history and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      good_cnt_q <= '0;
      prev_q_q   <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      prev_q_q   <= prev_q_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (err_inc),
    .sat_en (1'b1),
    .count  (err_count)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_wrap_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (wrap_inc),
    .sat_en (1'b0),
    .count  (wrap_count)
  );

  assign locked = locked_q;
  assign err    = err_q;

endmodule
